// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: stage write codes and FSM states.
package pipes;

  typedef logic [1:0] pwrite_t;

  localparam pwrite_t PW_LOAD  = 2'b00;
  localparam pwrite_t PW_FLUSH = 2'b01;
  localparam pwrite_t PW_HOLD  = 2'b10;

  typedef enum logic {HZ_RUN, HZ_PEND} hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_perf.sv
// Stall and flush performance counters for the hazard controller (built only with PIPE_PERF_EN).
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_stallCnt,
  output logic [CNT_W-1:0] o_flushCnt
);

  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (i_stall) r_stallCnt <= r_stallCnt + 1'b1;
      if (i_flush) r_flushCnt <= r_flushCnt + 1'b1;
    end
  end

  assign o_stallCnt = r_stallCnt;
  assign o_flushCnt = r_flushCnt;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: emits per-stage write codes and PC redirect select.
// Optional performance counters are enabled with the PIPE_PERF_EN macro.
module pipe_hazard_ctrl
  import pipes::*;
#(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_busy,
  input  logic              d_busy,
  input  logic              e_busy,
  input  logic              load_use,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output pwrite_t           FWrite,
  output pwrite_t           DWrite,
  output pwrite_t           EWrite,
  output pwrite_t           MWrite,
  output pwrite_t           WWrite,
  output logic              pc_sel,
  output logic [ADDR_W-1:0] pc_target,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  hz_state_t         r_state;
  hz_state_t         w_nextState;
  logic [ADDR_W-1:0] r_savedPc;
  logic              w_frozen;
  logic              w_redirRun;
  logic              w_pendDone;

  assign w_frozen   = d_busy | e_busy;
  assign w_redirRun = redirect & (r_state == HZ_RUN);
  assign w_pendDone = (r_state == HZ_PEND) & ~i_busy & ~load_use & ~w_frozen;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= HZ_RUN;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    if (!w_frozen) begin
      if (w_redirRun && i_busy) w_nextState = HZ_PEND;
      else if (w_pendDone)      w_nextState = HZ_RUN;
    end
  end

  // A redirect seen while in PEND simply replaces the target: last one wins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_savedPc <= '0;
    end else if (!w_frozen && redirect && (r_state == HZ_PEND || i_busy)) begin
      r_savedPc <= redirect_pc;
    end
  end

  always_comb begin
    FWrite    = PW_LOAD;
    DWrite    = PW_LOAD;
    EWrite    = PW_LOAD;
    MWrite    = PW_LOAD;
    WWrite    = PW_LOAD;
    pc_sel    = 1'b0;
    pc_target = '0;
    if (!reset) begin
      FWrite = PW_FLUSH;
      DWrite = PW_FLUSH;
      EWrite = PW_FLUSH;
      MWrite = PW_FLUSH;
      WWrite = PW_FLUSH;
    end else if (d_busy) begin
      FWrite = PW_HOLD;
      DWrite = PW_HOLD;
      EWrite = PW_HOLD;
      MWrite = PW_HOLD;
      WWrite = PW_FLUSH;
    end else if (e_busy) begin
      FWrite = PW_HOLD;
      DWrite = PW_HOLD;
      EWrite = PW_HOLD;
      MWrite = PW_FLUSH;
    end else if (w_redirRun && !i_busy) begin
      pc_sel    = 1'b1;
      pc_target = redirect_pc;
      DWrite    = PW_FLUSH;
      EWrite    = PW_FLUSH;
    end else if (w_redirRun) begin
      FWrite = PW_HOLD;
      DWrite = PW_FLUSH;
      EWrite = PW_FLUSH;
    end else if (load_use) begin
      FWrite = PW_HOLD;
      DWrite = PW_HOLD;
      EWrite = PW_FLUSH;
    end else if (r_state == HZ_PEND && !i_busy) begin
      // The fetch that just returned is on the wrong path; squash it and steer to the saved target.
      pc_sel    = 1'b1;
      pc_target = r_savedPc;
      DWrite    = PW_FLUSH;
    end else if (i_busy) begin
      FWrite = PW_HOLD;
      DWrite = PW_FLUSH;
    end
  end

`ifdef PIPE_PERF_EN
  logic w_flushEvt;
  logic w_stallEvt;

  assign w_flushEvt = reset & ~w_frozen & (w_redirRun | w_pendDone);
  assign w_stallEvt = (FWrite == PW_HOLD);

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk        (clk),
    .reset      (reset),
    .i_stall    (w_stallEvt),
    .i_flush    (w_flushEvt),
    .o_stallCnt (stall_cnt),
    .o_flushCnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; counter expectations follow PIPE_PERF_EN.
module tb_pipe_hazard_ctrl;
  import pipes::*;

  logic        clk = 1'b0;
  logic        reset, iBusy, dBusy, eBusy, loadUse, redirect;
  logic [63:0] redirectPc;
  pwrite_t     fWrite, dWrite, eWrite, mWrite, wWrite;
  logic        pcSel;
  logic [63:0] pcTarget;
  logic [31:0] stallCnt, flushCnt;
  logic [74:0] obs;
  logic [74:0] exp;
  int          testsRun = 0;
  int          testsFailed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.ADDR_W(64), .CNT_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_busy      (iBusy),
    .d_busy      (dBusy),
    .e_busy      (eBusy),
    .load_use    (loadUse),
    .redirect    (redirect),
    .redirect_pc (redirectPc),
    .FWrite      (fWrite),
    .DWrite      (dWrite),
    .EWrite      (eWrite),
    .MWrite      (mWrite),
    .WWrite      (wWrite),
    .pc_sel      (pcSel),
    .pc_target   (pcTarget),
    .stall_cnt   (stallCnt),
    .flush_cnt   (flushCnt)
  );

  // The target is only meaningful when pc_sel is set, so it is masked otherwise.
  assign obs = {fWrite, dWrite, eWrite, mWrite, wWrite, pcSel, (pcSel ? pcTarget : 64'h0)};

  task automatic applyStimulus(input logic rst, input logic ib, input logic db, input logic eb,
                               input logic lu, input logic rd, input logic [63:0] pc);
    @(negedge clk);
    reset = rst; iBusy = ib; dBusy = db; eBusy = eb;
    loadUse = lu; redirect = rd; redirectPc = pc;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h8000_0000);
      exp = {10'b01_01_01_01_01, 1'b0, 64'h0};
      testsRun++;
      if (obs !== exp || pcTarget !== 64'h0) begin
        testsFailed++;
        $display("[TB] FAIL reset_codes: got %h tgt %h, want %h tgt 0", obs, pcTarget, exp);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    exp = {10'b00_00_00_00_00, 1'b0, 64'h0};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL reset_release_idle: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_redirect();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h1000);
    exp = {10'b00_01_01_00_00, 1'b1, 64'h1000};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL redirect_now: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_pend();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2000);
    exp = {10'b10_01_01_00_00, 1'b0, 64'h0};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL pend_accept: got %h want %h", obs, exp);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      exp = {10'b10_01_00_00_00, 1'b0, 64'h0};
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL pend_wait: got %h want %h", obs, exp);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    exp = {10'b00_01_00_00_00, 1'b1, 64'h2000};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL pend_squash: got %h want %h", obs, exp);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    exp = {10'b00_00_00_00_00, 1'b0, 64'h0};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL pend_after: got %h want %h", obs, exp);
    end
    // Second redirect while pending replaces the saved target.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h2000);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h4000);
    exp = {10'b10_01_00_00_00, 1'b0, 64'h0};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL pend_redirect_codes: got %h want %h", obs, exp);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    exp = {10'b00_01_00_00_00, 1'b1, 64'h4000};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL pend_last_wins: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid_pend();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h5000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    exp = {10'b00_00_00_00_00, 1'b0, 64'h0};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_pend: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_ebusy_loaduse();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    exp = {10'b10_10_10_01_00, 1'b0, 64'h0};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL ebusy_over_loaduse: got %h want %h", obs, exp);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    exp = {10'b10_10_01_00_00, 1'b0, 64'h0};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL loaduse_alone: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_dbusy_pend();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h3000);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 64'hDEAD);
      exp = {10'b10_10_10_10_01, 1'b0, 64'h0};
      testsRun++;
      if (obs !== exp) begin
        testsFailed++;
        $display("[TB] FAIL dbusy_freeze: got %h want %h", obs, exp);
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    exp = {10'b00_01_00_00_00, 1'b1, 64'h3000};
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL dbusy_saved_pc: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_perf();
    logic [31:0] expStall;
    logic [31:0] expFlush;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    testsRun++;
    if (stallCnt !== 32'd0 || flushCnt !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL perf_clear: got %0d/%0d want 0/0", stallCnt, flushCnt);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h100);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 64'h200);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
`ifdef PIPE_PERF_EN
    expStall = 32'd5;
    expFlush = 32'd2;
`else
    expStall = 32'd0;
    expFlush = 32'd0;
`endif
    testsRun++;
    if (stallCnt !== expStall || flushCnt !== expFlush) begin
      testsFailed++;
      $display("[TB] FAIL perf_counts: got %0d/%0d want %0d/%0d", stallCnt, flushCnt, expStall, expFlush);
    end
  endtask

  initial begin
    reset = 1'b0; iBusy = 1'b0; dBusy = 1'b0; eBusy = 1'b0;
    loadUse = 1'b0; redirect = 1'b0; redirectPc = 64'h0;
    test_reset();
    test_redirect();
    test_pend();
    test_reset_mid_pend();
    test_ebusy_loaduse();
    test_dbusy_pend();
    test_perf();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control unit that drives the 2-bit write-control codes consumed by every stage register (F, D, E, M, W).
- Arbitrates memory-bus stalls, multi-cycle execute stalls, load-use interlocks and execute-stage redirects.
- Holds a redirect that arrives while a fetch is outstanding, then squashes the wrong-path fetch when it returns.
- Sits beside the datapath in the pipeline top; purely a control producer.

Parameters:
- ADDR_W, 64, width of redirect target / PC.
- CNT_W, 32, width of performance counters (PIPE_PERF_EN only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset asserted, sampled on posedge clk).
- i_busy  in  1  fetch waiting on instruction bus.
- d_busy  in  1  memory stage waiting on data bus.
- e_busy  in  1  multi-cycle mul/div occupying execute.
- load_use  in  1  decode source matches destination of a load in execute.
- redirect  in  1  branch/jump resolved taken in execute.
- redirect_pc  in  ADDR_W  redirect target.
- FWrite, DWrite, EWrite, MWrite, WWrite  out  2 each  stage write codes.
- pc_sel  out  1  1 = PC loads pc_target instead of sequential PC.
- pc_target  out  ADDR_W  PC source when pc_sel = 1.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Codes: 2'b00 LOAD, 2'b01 FLUSH (register cleared to zero), 2'b1x HOLD. The unit emits only 2'b10 for HOLD.
- All outputs are combinational from state and inputs; the only registered state is fsm, saved_pc and the counters.
- Reset asserted (reset=0): all five codes = FLUSH, pc_sel=0, pc_target=0, fsm=RUN, saved_pc=0, counters=0.
- FSM states:
  - RUN.
  - PEND: a redirect was accepted while i_busy=1; saved_pc holds the target.
- Priority, highest first; the first matching rule decides all codes:
  1. d_busy: F, D, E, M HOLD; W FLUSH. Redirect ignored this cycle.
  2. e_busy: F, D, E HOLD; M FLUSH; W LOAD. Redirect ignored.
  3. redirect in RUN with i_busy=0: F LOAD, pc_sel=1, pc_target=redirect_pc; D, E FLUSH; M, W LOAD.
  4. redirect in RUN with i_busy=1: saved_pc <= redirect_pc, fsm -> PEND next cycle; F HOLD; D, E FLUSH; M, W LOAD.
  5. load_use: F, D HOLD; E FLUSH; M, W LOAD.
  6. PEND with i_busy=1: F HOLD; D FLUSH; rest LOAD.
  7. PEND with i_busy=0: returned instruction is wrong path, so F LOAD with pc_sel=1 and pc_target=saved_pc; D FLUSH; rest LOAD; fsm -> RUN.
  8. i_busy in RUN: F HOLD; D FLUSH; rest LOAD.
  9. Otherwise all LOAD.
- Rules 1 and 2 freeze PEND: fsm and saved_pc are unchanged.
- redirect in PEND cannot occur: E has been flushed since the redirect. If it does occur, it overwrites saved_pc (last redirect wins).
- Reset mid-PEND returns to RUN with no redirect emitted.

Optional Feature:
- PIPE_PERF_EN defined:
  - stall_cnt increments on every cycle where FWrite is HOLD.
  - flush_cnt increments on every cycle where DWrite or EWrite is FLUSH due to rules 3, 4 or 7.
  - Both wrap modulo 2^CNT_W and clear on reset.
- Undefined: both outputs tied to 0 and no counter flops exist.

Decomposition:
- Package pipes holds:
  - typedef pwrite_t (u2);
  - constants PW_LOAD = 2'b00, PW_FLUSH = 2'b01, PW_HOLD = 2'b10;
  - typedef hz_state_t enum {HZ_RUN, HZ_PEND}.
- Address width uses the existing common addr type.
- One natural sub-module, hazard_perf_cnt, holding the two counters; instantiated only under PIPE_PERF_EN.

Test Plan:
- Reset held 3 cycles with redirect=1, redirect_pc=0x8000_0000 -> all codes 2'b01, pc_sel=0; fsm RUN after release.
- RUN, redirect=1, redirect_pc=0x1000, i_busy=0 -> FWrite=00, pc_sel=1, pc_target=0x1000, DWrite=EWrite=01, MWrite=WWrite=00.
- Redirect to 0x2000 with i_busy=1, i_busy held 3 more cycles then drops:
  - while pending: FWrite=10, DWrite=01;
  - on the cycle i_busy=0: pc_sel=1, pc_target=0x2000, DWrite=01;
  - following cycle: all 00.
- load_use=1 and e_busy=1 together -> e_busy rule wins: F/D/E=10, M=01, W=00; then load_use alone -> F/D=10, E=01.
- d_busy=1 while in PEND for 4 cycles -> F/D/E/M=10, W=01, saved_pc unchanged; after d_busy drops with i_busy=0 -> pc_target equals saved value.
- PIPE_PERF_EN: 5 load-use cycles + 2 redirects -> stall_cnt=5, flush_cnt=2. Without the macro, both read 0.
